// File: rtl/fetch_ctrl_pkg.sv
// Shared types and sizing for the fetch front end: instruction packet,
// fetch FSM encoding and default widths/depths.
package fetch_ctrl_pkg;

  localparam int          FETCH_N         = 2;
  localparam int          INST_BUFF_DEPTH = 8;
  localparam int          FETCH_MAX_OUT   = 4;
  localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        valid;
  } INST_PACKET;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    REDIR  = 2'd1,
    HALTED = 2'd2
  } FETCH_STATE;

  // Builds the buffer packet for word idx of a block starting at blk_pc.
  function automatic INST_PACKET make_packet(input logic [31:0] blk_pc,
                                             input logic [31:0] word,
                                             input int unsigned idx);
    INST_PACKET p;
    p.inst  = word;
    p.PC    = blk_pc + (32'(idx) << 2);
    p.NPC   = p.PC + 32'd4;
    p.valid = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer
// (master) and the memory (slave).
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
#(
  parameter int N = FETCH_N
) ();

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [31:0]     mem_req_addr;
  logic            mem_resp_valid;
  logic [N*32-1:0] mem_resp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data
  );

endinterface

// File: rtl/fetch_ctrl_chk.sv
// Protocol checks for the fetch sequencer: responses must match a request
// and live credit can never exceed the in-flight total.
module fetch_ctrl_chk #(
  parameter int OW = 3
) (
  input logic          clock,
  input logic          reset,
  input logic          resp_valid,
  input logic [OW-1:0] out_total,
  input logic [OW-1:0] out_live
);

  // Sampled once per cycle while out of reset.
  always @(posedge clock) begin
    if (reset) begin
      assert (!(resp_valid && out_total == {OW{1'b0}}))
        else $error("fetch_ctrl_chk: memory response with no outstanding request");
      assert (out_live <= out_total)
        else $error("fetch_ctrl_chk: live count %0d above total %0d", out_live, out_total);
    end
  end

endmodule

// File: rtl/fetch_tag_fifo.sv
// In-order FIFO of {epoch, block PC} for every outstanding memory request;
// the head always describes the next response to arrive.
module fetch_tag_fifo
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = FETCH_MAX_OUT,
  parameter int W     = 33,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & (count_r != {CW{1'b0}});

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
    end
  end

  // Tag storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clock) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues credit-checked block requests
// and turns in-order responses into instruction-buffer packets.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int          N        = FETCH_N,
  parameter int          DEPTH    = INST_BUFF_DEPTH,
  parameter int          MAX_OUT  = FETCH_MAX_OUT,
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  localparam int         CW       = $clog2(DEPTH + 1),
  localparam int         OW       = $clog2(MAX_OUT + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CW-1:0]     ib_open_entries,
  input  logic              br_en,
  input  logic [31:0]       br_target,
  input  logic              halt_fetch,
  fetch_ctrl_if.master      mem,
  output INST_PACKET        ib_insts [DEPTH],
  output logic [CW-1:0]     ib_num_accept,
  output logic [1:0]        fetch_state
);

  FETCH_STATE    state_r;
  FETCH_STATE    state_nxt_s;
  logic [31:0]   pc_r;
  logic          epoch_r;
  logic [OW-1:0] out_live_r;
  logic [OW-1:0] out_total_s;
  logic          fifo_full_s;
  logic [32:0]   head_s;
  logic          head_epoch_s;
  logic [31:0]   head_pc_s;
  logic [31:0]   credit_need_s;
  logic          credit_ok_s;
  logic          issue_s;
  logic          hs_s;
  logic          resp_s;
  logic          live_s;

  assign head_epoch_s = head_s[32];
  assign head_pc_s    = head_s[31:0];

  // Space for every live block plus the new one must already be open.
  assign credit_need_s = 32'(N) * (32'(out_live_r) + 32'd1);
  assign credit_ok_s   = (32'(ib_open_entries) >= credit_need_s);

  assign issue_s = reset & (state_r == FETCH) & ~br_en & ~halt_fetch
                 & ~fifo_full_s & credit_ok_s;
  assign hs_s    = issue_s & mem.mem_req_ready;
  assign resp_s  = reset & mem.mem_resp_valid;
  assign live_s  = resp_s & (head_epoch_s == epoch_r) & ~br_en;

  assign mem.mem_req_valid = issue_s;
  assign mem.mem_req_addr  = reset ? pc_r : 32'd0;
  assign fetch_state       = reset ? 2'(state_r) : 2'd0;

  fetch_tag_fifo #(
    .DEPTH (MAX_OUT),
    .W     (33)
  ) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (hs_s),
    .push_data ({epoch_r, pc_r}),
    .pop       (resp_s),
    .head      (head_s),
    .count     (out_total_s),
    .full      (fifo_full_s)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; redirect outranks halt.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FETCH: begin
        if (br_en) begin
          state_nxt_s = REDIR;
        end else if (halt_fetch) begin
          state_nxt_s = HALTED;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      REDIR: state_nxt_s = FETCH;
      HALTED: begin
        if (br_en) begin
          state_nxt_s = REDIR;
        end else begin
          state_nxt_s = HALTED;
        end
      end
      default: state_nxt_s = FETCH;
    endcase
  end

  // PC, epoch and live-credit tracking; a redirect abandons all live credit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_r       <= RESET_PC;
      epoch_r    <= 1'b0;
      out_live_r <= {OW{1'b0}};
    end else if (br_en) begin
      pc_r       <= br_target;
      epoch_r    <= ~epoch_r;
      out_live_r <= {OW{1'b0}};
    end else begin
      if (hs_s) pc_r <= pc_r + 32'(4 * N);
      out_live_r <= out_live_r + OW'(hs_s) - OW'(live_s);
    end
  end

  // Zero-latency response path into the buffer; stale blocks are dropped.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ib_insts[i] = '0;
    end
    ib_num_accept = {CW{1'b0}};
    if (live_s) begin
      for (int i = 0; i < N; i++) begin
        ib_insts[i] = make_packet(head_pc_s, mem.mem_resp_data[32*i +: 32], i);
      end
      ib_num_accept = CW'(N);
    end else begin
      ib_num_accept = {CW{1'b0}};
    end
  end

  fetch_ctrl_chk #(
    .OW (OW)
  ) u_chk (
    .clock      (clock),
    .reset      (reset),
    .resp_valid (mem.mem_resp_valid),
    .out_total  (out_total_s),
    .out_live   (out_live_r)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with N=2, DEPTH=8, MAX_OUT=4; the memory
// side is driven by hand, one cycle per step.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  ib_open_entries;
  logic        br_en;
  logic [31:0] br_target;
  logic        halt_fetch;
  INST_PACKET  ib_insts [8];
  logic [3:0]  ib_num_accept;
  logic [1:0]  fetch_state;
  int          total = 0;
  int          bad   = 0;

  always #5 clock = ~clock;

  fetch_ctrl_if #(.N(2)) mif ();

  fetch_ctrl #(
    .N        (2),
    .DEPTH    (8),
    .MAX_OUT  (4),
    .RESET_PC (32'h0)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .ib_open_entries (ib_open_entries),
    .br_en           (br_en),
    .br_target       (br_target),
    .halt_fetch      (halt_fetch),
    .mem             (mif),
    .ib_insts        (ib_insts),
    .ib_num_accept   (ib_num_accept),
    .fetch_state     (fetch_state)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic INST_PACKET pk(input logic [31:0] inst, input logic [31:0] pc);
    INST_PACKET p;
    p.inst  = inst;
    p.PC    = pc;
    p.NPC   = pc + 32'd4;
    p.valid = 1'b1;
    return p;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [31:0] d1,
                      input logic [31:0] d0, input logic [3:0] open,
                      input logic br, input logic [31:0] tgt, input logic hlt);
    mif.mem_req_ready  = rdy;
    mif.mem_resp_valid = rv;
    mif.mem_resp_data  = {d1, d0};
    ib_open_entries    = open;
    br_en              = br;
    br_target          = tgt;
    halt_fetch         = hlt;
    #1;
  endtask

  task automatic req(input string tag, input logic v, input logic [31:0] a);
    chk({tag, ".req_valid"}, 128'(mif.mem_req_valid), 128'(v));
    if (v) chk({tag, ".req_addr"}, 128'(mif.mem_req_addr), 128'(a));
  endtask

  task automatic rsp(input string tag, input logic [3:0] na, input logic [31:0] pc0,
                     input logic [31:0] i0, input logic [31:0] i1);
    chk({tag, ".num_accept"}, 128'(ib_num_accept), 128'(na));
    if (na != 4'd0) begin
      chk({tag, ".slot0"}, 128'(ib_insts[0]), 128'(pk(i0, pc0)));
      chk({tag, ".slot1"}, 128'(ib_insts[1]), 128'(pk(i1, pc0 + 32'd4)));
    end else begin
      chk({tag, ".slot0_zero"}, 128'(ib_insts[0]), 128'd0);
    end
    chk({tag, ".slot2_zero"}, 128'(ib_insts[2]), 128'd0);
  endtask

  task automatic st(input string tag, input logic [1:0] s);
    chk({tag, ".state"}, 128'(fetch_state), 128'(s));
  endtask

  initial begin
    reset = 1'b0;
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd8, 1'b0, 32'h0, 1'b0);
    cyc(); cyc();
    // Outputs held at zero during reset
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd8, 1'b0, 32'h0, 1'b0);
    req("rst", 1'b0, 32'h0);
    chk("rst.addr", 128'(mif.mem_req_addr), 128'd0);
    rsp("rst", 4'd0, 32'h0, 32'h0, 32'h0);
    st("rst", 2'd0);
    cyc();

    // Back-to-back fetch with a one-cycle memory
    reset = 1'b1;
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd8, 1'b0, 32'h0, 1'b0);
    req("c0", 1'b1, 32'h0); cyc();
    step(1'b1, 1'b1, 32'h11, 32'h10, 4'd8, 1'b0, 32'h0, 1'b0);
    rsp("c1", 4'd2, 32'h0, 32'h10, 32'h11); req("c1", 1'b1, 32'h8); cyc();
    step(1'b0, 1'b1, 32'h21, 32'h20, 4'd8, 1'b0, 32'h0, 1'b0);
    rsp("c2", 4'd2, 32'h8, 32'h20, 32'h21); req("c2", 1'b1, 32'h10); cyc();

    // Credit stall with open_entries = 4
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd4, 1'b0, 32'h0, 1'b0);
    req("c3", 1'b1, 32'h10); cyc();
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd4, 1'b0, 32'h0, 1'b0);
    req("c4", 1'b1, 32'h18); cyc();
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd4, 1'b0, 32'h0, 1'b0);
    req("c5", 1'b0, 32'h0); rsp("c5", 4'd0, 32'h0, 32'h0, 32'h0); cyc();
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd4, 1'b0, 32'h0, 1'b0);
    req("c6", 1'b0, 32'h0); cyc();
    step(1'b1, 1'b1, 32'h31, 32'h30, 4'd4, 1'b0, 32'h0, 1'b0);
    rsp("c7", 4'd2, 32'h10, 32'h30, 32'h31); req("c7", 1'b0, 32'h0); cyc();
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd4, 1'b0, 32'h0, 1'b0);
    req("c8", 1'b1, 32'h20); cyc();

    // Fill to MAX_OUT outstanding
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd8, 1'b0, 32'h0, 1'b0);
    req("c9", 1'b1, 32'h28); cyc();
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd8, 1'b0, 32'h0, 1'b0);
    req("c10", 1'b1, 32'h30); cyc();
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd15, 1'b0, 32'h0, 1'b0);
    req("c11_full", 1'b0, 32'h0); cyc();
    step(1'b1, 1'b1, 32'h41, 32'h40, 4'd15, 1'b0, 32'h0, 1'b0);
    rsp("c12", 4'd2, 32'h18, 32'h40, 32'h41); req("c12_full", 1'b0, 32'h0); cyc();
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'd15, 1'b0, 32'h0, 1'b0);
    req("c13", 1'b1, 32'h38); cyc();

    // Redirect with three stale blocks in flight
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd15, 1'b1, 32'h100, 1'b0);
    req("c14_br", 1'b0, 32'h0); st("c14", 2'd0); cyc();
    step(1'b1, 1'b1, 32'h51, 32'h50, 4'd15, 1'b0, 32'h0, 1'b0);
    st("c15", 2'd1); req("c15_redir", 1'b0, 32'h0); rsp("c15_stale", 4'd0, 32'h0, 32'h0, 32'h0); cyc();
    step(1'b0, 1'b1, 32'h55, 32'h54, 4'd15, 1'b0, 32'h0, 1'b0);
    st("c16", 2'd0); req("c16", 1'b1, 32'h100); rsp("c16_stale", 4'd0, 32'h0, 32'h0, 32'h0); cyc();
    step(1'b1, 1'b1, 32'h57, 32'h56, 4'd15, 1'b0, 32'h0, 1'b0);
    rsp("c17_stale", 4'd0, 32'h0, 32'h0, 32'h0); req("c17", 1'b1, 32'h100); cyc();
    step(1'b0, 1'b1, 32'h61, 32'h60, 4'd15, 1'b0, 32'h0, 1'b0);
    rsp("c18", 4'd2, 32'h100, 32'h60, 32'h61); req("c18", 1'b1, 32'h108); cyc();

    // Redirect coinciding with a live response
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd15, 1'b0, 32'h0, 1'b0);
    req("c19", 1'b1, 32'h108); cyc();
    step(1'b1, 1'b1, 32'h71, 32'h70, 4'd15, 1'b1, 32'h200, 1'b0);
    rsp("c20_drop", 4'd0, 32'h0, 32'h0, 32'h0); req("c20", 1'b0, 32'h0); cyc();
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd15, 1'b0, 32'h0, 1'b0);
    st("c21", 2'd1); req("c21", 1'b0, 32'h0); cyc();
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd15, 1'b0, 32'h0, 1'b0);
    st("c22", 2'd0); req("c22", 1'b1, 32'h200); cyc();
    for (int k = 1; k < 4; k++) begin
      step(1'b1, 1'b0, 32'h0, 32'h0, 4'd15, 1'b0, 32'h0, 1'b0);
      req($sformatf("c%0d", 22 + k), 1'b1, 32'h200 + 32'(8 * k)); cyc();
    end

    // Halt: no issue, responses still accepted, redirect out of HALTED
    step(1'b1, 1'b1, 32'h81, 32'h80, 4'd15, 1'b0, 32'h0, 1'b1);
    rsp("c26", 4'd2, 32'h200, 32'h80, 32'h81); req("c26", 1'b0, 32'h0); cyc();
    step(1'b1, 1'b1, 32'h91, 32'h90, 4'd15, 1'b0, 32'h0, 1'b1);
    st("c27", 2'd2); rsp("c27", 4'd2, 32'h208, 32'h90, 32'h91); req("c27", 1'b0, 32'h0); cyc();
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd15, 1'b0, 32'h0, 1'b0);
    st("c28", 2'd2); req("c28", 1'b0, 32'h0); cyc();
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd15, 1'b1, 32'h40, 1'b0);
    st("c29", 2'd2); req("c29", 1'b0, 32'h0); cyc();
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd15, 1'b0, 32'h0, 1'b0);
    st("c30", 2'd1); req("c30", 1'b0, 32'h0); cyc();
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'd15, 1'b0, 32'h0, 1'b0);
    st("c31", 2'd0); req("c31", 1'b1, 32'h40); cyc();

    // Reset mid-stream clears counters and PC
    reset = 1'b0;
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd15, 1'b0, 32'h0, 1'b0);
    req("c32_rst", 1'b0, 32'h0); chk("c32_rst.addr", 128'(mif.mem_req_addr), 128'd0);
    st("c32_rst", 2'd0); cyc();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 32'h0, 32'h0, 4'd8, 1'b0, 32'h0, 1'b0);
      req($sformatf("c%0d", 33 + k), 1'b1, 32'(8 * k)); cyc();
    end
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'd8, 1'b0, 32'h0, 1'b0);
    req("c37_full", 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
